// File: rtl/local_bus_pkg.sv
// local_bus_pkg: shared constants and helpers for the round-robin local register bus.
//   DATA_W_DEF   default register/data width
//   NUM_REGS_DEF default number of local registers
//   REG_ZERO     index of the hard-wired zero register
//   sel_w(n)     width of a register index for n registers (at least 1 bit)
package local_bus_pkg;
   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int REG_ZERO     = 0;
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/local_bus_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with eligibility mask and internal priority pointer.
//   i_clk      clock, rising edge
//   i_reset    asynchronous active-low reset; pointer returns to 0
//   i_req      per-requester request
//   i_mask     per-requester eligibility; a masked requester is never granted
//   o_gnt      one-hot combinational grant, zero when nothing eligible
//   o_ptr_nxt  (winner+1) mod N, loaded into the pointer on any grant
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [N-1:0]         i_req,
   input  logic [N-1:0]         i_mask,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_ptr_nxt
);
   localparam int PW = $clog2(N);
   localparam logic [PW:0] N_L = (PW+1)'(N);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_off;
   logic [PW-1:0] w_win;
   logic [PW:0]   w_sum;
   logic [N-1:0]  w_elig;
   logic [N-1:0]  w_rot;

   assign w_elig = i_req & i_mask;
   // Rotate so the pointer position lands at bit 0; the lowest set bit is then the winner's offset.
   assign w_rot  = N'({w_elig, w_elig} >> r_ptr);

   always_comb begin
      w_off = '0;
      for (int j = N - 1; j >= 0; j--)
         if (w_rot[j]) w_off = PW'(j);
   end

   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win     = (w_sum >= N_L) ? PW'(w_sum - N_L) : w_sum[PW-1:0];
   assign o_gnt     = (|w_elig) ? (N'(1) << w_win) : '0;
   assign o_ptr_nxt = ({1'b0, w_win} == N_L - (PW+1)'(1)) ? '0 : w_win + PW'(1);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_ptr <= '0;
      else if (|w_elig) r_ptr <= o_ptr_nxt;
   end
endmodule

// File: rtl/local_bus_rr.sv
// local_bus_rr: N_PE processing elements share a local register file through a round-robin arbiter.
//   Optional macro LOCAL_BUS_LOCK_EN enables bounded bus locking via i_lock.
//   i_clk      clock, rising edge
//   i_reset    asynchronous active-low reset
//   i_req      per-PE transaction request (level)
//   i_we       per-PE write enable
//   i_rd_sel   per-PE write index, PE i at [i*SEL_W +: SEL_W]
//   i_rs1_sel  per-PE read port 1 index
//   i_rs2_sel  per-PE read port 2 index
//   i_wdata    per-PE write data, PE i at [i*DATA_W +: DATA_W]
//   i_lock     per-PE lock request (ignored without LOCAL_BUS_LOCK_EN)
//   o_gnt      one-hot combinational grant
//   o_rvalid   one-hot registered, the cycle after o_gnt
//   o_rdata1   registered read port 1 data
//   o_rdata2   registered read port 2 data
//   o_busy     registered, some request was left ungranted
module local_bus_rr
   import local_bus_pkg::*;
#(
   parameter  int N_PE     = 4,
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int LOCK_MAX = 4,
   localparam int SEL_W    = sel_w(NUM_REGS)
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_PE-1:0]        i_req,
   input  logic [N_PE-1:0]        i_we,
   input  logic [N_PE*SEL_W-1:0]  i_rd_sel,
   input  logic [N_PE*SEL_W-1:0]  i_rs1_sel,
   input  logic [N_PE*SEL_W-1:0]  i_rs2_sel,
   input  logic [N_PE*DATA_W-1:0] i_wdata,
   input  logic [N_PE-1:0]        i_lock,
   output logic [N_PE-1:0]        o_gnt,
   output logic [N_PE-1:0]        o_rvalid,
   output logic [DATA_W-1:0]      o_rdata1,
   output logic [DATA_W-1:0]      o_rdata2,
   output logic                   o_busy
);
   localparam int PW = $clog2(N_PE);
   localparam logic [SEL_W:0] NR_L = (SEL_W+1)'(NUM_REGS);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [N_PE-1:0]   w_gnt;
   logic [N_PE-1:0]   w_mask;
   logic [PW-1:0]     w_win;
   logic [PW-1:0]     w_unused_ptr;
   logic [SEL_W-1:0]  w_rd;
   logic [SEL_W-1:0]  w_rs1;
   logic [SEL_W-1:0]  w_rs2;
   logic [DATA_W-1:0] w_wd;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_wr_ok;

   rr_arbiter #(.N(N_PE)) u_arb (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_req     (i_req),
      .i_mask    (w_mask),
      .o_gnt     (w_gnt),
      .o_ptr_nxt (w_unused_ptr)
   );

   assign o_gnt = w_gnt;

   always_comb begin
      w_win = '0;
      for (int i = 0; i < N_PE; i++)
         if (w_gnt[i]) w_win = PW'(i);
   end

   assign w_rd  = i_rd_sel[w_win*SEL_W +: SEL_W];
   assign w_rs1 = i_rs1_sel[w_win*SEL_W +: SEL_W];
   assign w_rs2 = i_rs2_sel[w_win*SEL_W +: SEL_W];
   assign w_wd  = i_wdata[w_win*DATA_W +: DATA_W];
   // Register 0 is never written, so it reads back as zero without a special case.
   assign w_rd1 = ({1'b0, w_rs1} < NR_L) ? r_regs[w_rs1] : '0;
   assign w_rd2 = ({1'b0, w_rs2} < NR_L) ? r_regs[w_rs2] : '0;
   assign w_wr_ok = (|w_gnt) & i_we[w_win] & (w_rd != SEL_W'(REG_ZERO)) & ({1'b0, w_rd} < NR_L);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         o_rvalid <= '0;
         o_rdata1 <= '0;
         o_rdata2 <= '0;
         o_busy   <= 1'b0;
      end else begin
         o_rvalid <= w_gnt;
         o_busy   <= |(i_req & ~w_gnt);
         if (|w_gnt) begin
            o_rdata1 <= w_rd1;
            o_rdata2 <= w_rd2;
         end
         if (w_wr_ok) r_regs[w_rd] <= w_wd;
      end
   end

`ifdef LOCAL_BUS_LOCK_EN
   localparam int CW = $clog2(LOCK_MAX + 1);

   logic            r_lock_act;
   logic            r_excl;
   logic [PW-1:0]   r_owner;
   logic [CW-1:0]   r_cnt;
   logic [N_PE-1:0] w_own;
   logic            w_hold;
   logic            w_others;
   logic            w_acq;

   assign w_own    = N_PE'(1) << r_owner;
   assign w_hold   = r_lock_act & i_req[r_owner] & i_lock[r_owner];
   assign w_others = |(i_req & ~w_own);
   // A holding owner is the only candidate; after a forced release it sits out one contested round.
   assign w_mask   = w_hold ? w_own : (r_excl & w_others) ? ~w_own : '1;
   assign w_acq    = (|w_gnt) & i_lock[w_win] & ~(r_excl & (w_win == r_owner));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_lock_act <= 1'b0;
         r_excl     <= 1'b0;
         r_owner    <= '0;
         r_cnt      <= '0;
      end else if (w_hold) begin
         if (r_cnt == CW'(LOCK_MAX - 1)) begin
            r_lock_act <= 1'b0;
            r_excl     <= 1'b1;
            r_cnt      <= '0;
         end else r_cnt <= r_cnt + CW'(1);
      end else begin
         r_lock_act <= 1'b0;
         if (r_excl & w_others) r_excl <= 1'b0;
         if (w_acq) begin
            r_lock_act <= 1'b1;
            r_owner    <= w_win;
            r_cnt      <= CW'(1);
            r_excl     <= 1'b0;
         end
      end
   end
`else
   localparam int UNUSED_LOCK_MAX = LOCK_MAX;
   logic w_unused_lock;
   assign w_unused_lock = ^i_lock;
   assign w_mask = '1;
`endif
endmodule

// File: doc/local_bus_rr.md
Name: local_bus_rr

Overview:
- Parametrised successor of the cluster local bus.
- N_PE processing elements share one local register file through a round-robin arbiter with per-PE request/grant handshake.
- Each granted transaction performs one optional write plus two reads in a single cycle; read data returns registered one cycle later, tagged per PE.
- Sits between the PE array and the cluster's shared data registers.

Parameters:
- N_PE, 4, number of PE channels (2..16)
- DATA_W, 32, register and data width
- NUM_REGS, 32, local registers; SEL_W = $clog2(NUM_REGS)
- LOCK_MAX, 4, maximum consecutive grants under lock (used only with LOCAL_BUS_LOCK_EN)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_PE  per-PE transaction request, level
- we  in  N_PE  per-PE write enable for the transaction
- rd_sel  in  N_PE*SEL_W  per-PE write register index, PE i at [i*SEL_W +: SEL_W]
- rs1_sel  in  N_PE*SEL_W  per-PE read port 1 index
- rs2_sel  in  N_PE*SEL_W  per-PE read port 2 index
- wdata  in  N_PE*DATA_W  per-PE write data
- lock  in  N_PE  per-PE lock request; ignored unless LOCAL_BUS_LOCK_EN
- gnt  out  N_PE  one-hot grant, combinational, same cycle as winning req
- rvalid  out  N_PE  one-hot, registered; high the cycle after gnt
- rdata1  out  DATA_W  registered read port 1 data, valid with rvalid
- rdata2  out  DATA_W  registered read port 2 data, valid with rvalid
- busy  out  1  registered; high while any req is pending and not granted

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers 0; rr pointer = 0 (PE0 highest priority)
  - rvalid = 0, rdata1 = rdata2 = 0, busy = 0, lock state cleared
- Arbitration:
  - gnt = first set bit of req, searching from the rr pointer upward with wrap-around.
  - At most one gnt bit is high; gnt = 0 when req = 0.
- Pointer update: on an edge with any gnt, pointer <= (winner+1) mod N_PE. With no grant, the pointer holds.
- Handshake:
  - A PE holds req and its selects/data stable until it sees gnt.
  - The transaction commits on the edge that ends the gnt cycle.
  - Keeping req high after gnt requests a new transaction; it competes normally.
- Transaction on the commit edge:
  - rdata1 <= reg[rs1], rdata2 <= reg[rs2], using pre-write values. A read of the register written in the same transaction returns the old value.
  - If we=1 and rd != 0: reg[rd] <= wdata.
  - rvalid <= gnt.
- Register 0: always reads 0; writes to it are discarded.
- Latency: 1 cycle from gnt to rvalid. Throughput is one transaction per cycle. rdata holds its last value when rvalid = 0.
- Indices >= NUM_REGS: the read returns 0 and the write is discarded (relevant only when NUM_REGS is not a power of 2).
- busy <= |(req & ~gnt).
- Fairness: with all PEs requesting continuously, each PE is granted exactly once every N_PE cycles.
- Reset mid-transaction: a pending rvalid is cancelled, and no write occurs unless its edge completed before reset fell.

Optional Feature:
- Macro: LOCAL_BUS_LOCK_EN
- Defined:
  - If the granted PE has lock=1 at commit, it becomes the lock owner.
  - While the owner holds req&lock, only the owner is eligible. The rr pointer is frozen at owner+1.
  - After LOCK_MAX consecutive owner grants, the lock is force-released. The owner is then ineligible for exactly one arbitration cycle in which any other PE requests.
  - When the owner drops req or lock, the lock releases immediately and normal round-robin resumes.
- Undefined: the lock port is ignored, no lock state is synthesised, and arbitration is pure round-robin.

Decomposition:
- Package local_bus_pkg holds:
  - sel_w(n) function
  - DATA_W_DEF and NUM_REGS_DEF constants
  - REG_ZERO index constant
- Sub-module rr_arbiter (parameter N; inputs req, mask; outputs one-hot gnt and next pointer; contains the pointer register).
- Register file, lock logic and read-out registers stay in the top module.

Test Plan:
- Reset then single write: PE2 req, we=1, rd=5, wdata=0xDEADBEEF → gnt=0100 same cycle. Then PE0 reads rs1=5 → rdata1=0xDEADBEEF with rvalid=0001 one cycle after its gnt.
- Round-robin: req=1111 held for 8 cycles from reset → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; busy=1 throughout.
- Same-transaction read/write: reg7=0x11; PE1 we=1, rd=7, rs1=7, wdata=0x22 → rdata1=0x11. Next read of reg7 → 0x22.
- Register 0: PE3 writes 0xFFFFFFFF to rd=0, then reads rs1=0, rs2=0 → rdata1=rdata2=0.
- Async reset mid-stream: reset falls between edges during req=1111 → gnt pointer, rvalid, rdata and busy are 0 immediately. After release, PE0 is granted first.
- Lock (LOCAL_BUS_LOCK_EN, LOCK_MAX=4): PE1 req+lock, PE0 and PE2 req → PE1 granted 4 consecutive cycles, then PE2 is granted. Rebuilt without the macro → gnt alternates 0010, 0100, 0001.
